sem_fases: RTL and testbench
============================

Name: sem_fases

Overview:
- Phase controller sitting directly downstream of the 4 Hz traffic-light tick counter.
- Consumes the counter's CUENTA/TC and decodes them into registered car and pedestrian light outputs.
- Handles a pedestrian push-button. When a request arrives early in car green, it shortens the green phase by driving the counter's LOADn/P inputs.
- Counter tick = 0.25 s; one full cycle = MODULE ticks.

Parameters:
MODULE, 55, counter modulus; CUENTA ranges 0..MODULE-1
T_SALTO, 12, CUENTA value loaded when a pedestrian request shortens green
T_AMBAR, 20, first CUENTA of car amber
T_ROJO, 24, first CUENTA of all-red clearance 1
T_PEA, 26, first CUENTA of pedestrian green
T_PARP, 44, first CUENTA of pedestrian blinking green
T_FIN, 50, first CUENTA of all-red clearance 2
Legal only if 0 < T_SALTO < T_AMBAR < T_ROJO < T_PEA < T_PARP < T_FIN <= MODULE-1.

Ports:
CLK  in  1  system clock (50 MHz)
RSTn  in  1  asynchronous reset, active low
CLK_ENA  in  1  global enable; FSM and light registers update only when 1
CUENTA  in  6  tick count from the counter
TC  in  1  counter terminal count (CUENTA == MODULE-1 with tick)
PEAT_REQ  in  1  pedestrian button, debounced, asynchronous to CLK
SEM_LOADn  out  1  counter load strobe, active low
SEM_P  out  6  counter load value
CAR_R, CAR_A, CAR_V  out  1 each  car red/amber/green
PEA_R, PEA_V  out  1 each  pedestrian red/green
PEAT_ESPERA  out  1  pending pedestrian request indicator
FASE  out  3  current state encoding, for debug

Behaviour:
- Reset (async, RSTn=0), effective immediately:
  - state=INICIO; CAR_R=1, PEA_R=1, all other lights 0.
  - SEM_LOADn=1, SEM_P=0, PEAT_ESPERA=0, synchroniser flops 0.
- PEAT_REQ is synchronised with 2 flip-flops, then rising-edge detected. The synchroniser and edge detector are clocked every CLK, independent of CLK_ENA.
- States and CUENTA decode (evaluated only when CLK_ENA=1; all outputs registered, 1-cycle latency):
  - INICIO: all-red; next state is the one whose CUENTA window contains the current CUENTA.
  - VERDE: CUENTA 0..T_AMBAR-1. CAR_V=1, PEA_R=1.
  - AMBAR: T_AMBAR..T_ROJO-1. CAR_A=1, PEA_R=1.
  - ROJO1: T_ROJO..T_PEA-1. CAR_R=1, PEA_R=1.
  - PEATON: T_PEA..T_PARP-1. CAR_R=1, PEA_V=1.
  - PARP: T_PARP..T_FIN-1. CAR_R=1, PEA_V=CUENTA[0] (2 Hz blink).
  - ROJO2: T_FIN..MODULE-1. CAR_R=1, PEA_R=1.
- Transitions: each state advances when CUENTA equals the next state's first value. ROJO2→VERDE when CUENTA==0. TC alone does not change state.
- Exactly one of CAR_R/CAR_A/CAR_V is 1 outside reset. PEA_V and CAR_V are never both 1.
- Request latch (PEAT_ESPERA):
  - Set on a request edge in VERDE, PARP or ROJO2.
  - Edges in AMBAR, ROJO1 or PEATON are ignored.
  - Cleared on entry to PEATON.
  - An edge coincident with the PEATON entry is ignored.
- Shortening:
  - In VERDE with PEAT_ESPERA=1 and CUENTA < T_SALTO: drive SEM_LOADn=0, SEM_P=T_SALTO.
  - Hold both until CUENTA==T_SALTO is sampled, then SEM_LOADn=1 next cycle. This handshake tolerates the counter applying the load only on its enable.
  - CUENTA ≥ T_SALTO in VERDE: no load is issued.
  - SEM_P returns to 0 when SEM_LOADn is released.
- Load hold does not depend on CLK_ENA.
- Reset mid-load releases SEM_LOADn immediately.
- A CUENTA value outside the current window other than the next threshold (e.g. after an external load) puts the FSM in INICIO for one enabled cycle, which resynchronises it.

Optional Feature:
- Macro SEM_NOCHE_EN.
- Defined:
  - Adds input port NOCHE (1 bit). NOCHE=1 forces state NOCHE: CAR_A=CUENTA[1], all other lights 0, SEM_LOADn=1, PEAT_ESPERA cleared and held 0.
  - NOCHE falling → INICIO.
- Undefined: no NOCHE port; the behaviour above is unchanged.

Test Plan:
- Reset with CUENTA=0, then release, CLK_ENA=1 → INICIO all-red for 1 cycle, then VERDE: CAR_V=1, PEA_R=1.
- Sweep CUENTA 0..54 with no request → light changes occur 1 cycle after CUENTA=20, 24, 26, 44, 50, 0. In PARP, PEA_V toggles with CUENTA[0].
- PEAT_REQ pulse at CUENTA=5 → PEAT_ESPERA=1 about 3 cycles later; SEM_LOADn=0 with SEM_P=12. Model CUENTA jumping to 12 → SEM_LOADn=1 the next cycle; stays in VERDE; PEAT_ESPERA clears on entering PEATON at 26.
- PEAT_REQ at CUENTA=15 → PEAT_ESPERA=1, no load. PEAT_REQ at CUENTA=30 (PEATON) → ignored, PEAT_ESPERA stays 0.
- RSTn low while SEM_LOADn=0 → SEM_LOADn=1, CAR_R=1 without a clock edge.
- SEM_NOCHE_EN defined: NOCHE=1 at CUENTA=30 → PEA_V=0, CAR_A follows CUENTA[1]. NOCHE=0 → INICIO, then PEATON.

Source files
------------

// File: rtl/sem_fases.sv
// sem_fases: traffic-light phase controller driven by the 4 Hz tick counter (CUENTA/TC).
// Optional night mode (NOCHE input and state) is built when SEM_NOCHE_EN is defined.
module sem_fases #(
    parameter int MODULE  = 55,
    parameter int T_SALTO = 12,
    parameter int T_AMBAR = 20,
    parameter int T_ROJO  = 24,
    parameter int T_PEA   = 26,
    parameter int T_PARP  = 44,
    parameter int T_FIN   = 50
) (
    input  logic       CLK,
    input  logic       RSTn,
`ifdef SEM_NOCHE_EN
    input  logic       NOCHE,
`endif
    input  logic       CLK_ENA,
    input  logic [5:0] CUENTA,
    input  logic       TC,
    input  logic       PEAT_REQ,
    output logic       SEM_LOADn,
    output logic [5:0] SEM_P,
    output logic       CAR_R,
    output logic       CAR_A,
    output logic       CAR_V,
    output logic       PEA_R,
    output logic       PEA_V,
    output logic       PEAT_ESPERA,
    output logic [2:0] FASE
);

    typedef enum logic [2:0] {
        S_INICIO = 3'd0,
        S_VERDE  = 3'd1,
        S_AMBAR  = 3'd2,
        S_ROJO1  = 3'd3,
        S_PEATON = 3'd4,
        S_PARP   = 3'd5,
        S_ROJO2  = 3'd6,
        S_NOCHE  = 3'd7
    } fase_t;

    localparam logic [5:0] C_ZERO  = 6'd0;
    localparam logic [5:0] C_SALTO = 6'(T_SALTO);
    localparam logic [5:0] C_AMBAR = 6'(T_AMBAR);
    localparam logic [5:0] C_ROJO  = 6'(T_ROJO);
    localparam logic [5:0] C_PEA   = 6'(T_PEA);
    localparam logic [5:0] C_PARP  = 6'(T_PARP);
    localparam logic [5:0] C_FIN   = 6'(T_FIN);
    localparam logic [5:0] C_ULT   = 6'(MODULE - 1);

    // Light vectors are packed as {CAR_R, CAR_A, CAR_V, PEA_R, PEA_V}
    localparam logic [4:0] L_TODO_ROJO = 5'b10010;
    localparam logic [4:0] L_VERDE     = 5'b00110;
    localparam logic [4:0] L_AMBAR     = 5'b01010;
    localparam logic [4:0] L_PEATON    = 5'b10001;

    if (!((T_SALTO > 0) && (T_SALTO < T_AMBAR) && (T_AMBAR < T_ROJO) && (T_ROJO < T_PEA) &&
          (T_PEA < T_PARP) && (T_PARP < T_FIN) && (T_FIN <= MODULE - 1) && (MODULE <= 64))) begin : g_bad_params
        $error("sem_fases: illegal phase thresholds");
    end

    fase_t      state_r, state_nx_s;
    logic [4:0] luces_r, luces_nx_s;
    logic       sync1_r, sync2_r, prev_r, edge_s;
    logic       espera_r, espera_nx_s;
    logic       loadn_r, loadn_nx_s;
    logic [5:0] p_r, p_nx_s;
    logic       noche_s, noche_act_s, entra_peaton_s, fase_pide_s;
    logic       unused_tc_s;

    // TC is redundant with CUENTA for phase decoding
    assign unused_tc_s = TC;

`ifdef SEM_NOCHE_EN
    assign noche_s = NOCHE;
`else
    assign noche_s = 1'b0;
`endif

    // Phase whose CUENTA window contains c; out-of-range counts map to INICIO
    function automatic fase_t ventana(input logic [5:0] c);
        fase_t f;
        if (c < C_AMBAR)      f = S_VERDE;
        else if (c < C_ROJO)  f = S_AMBAR;
        else if (c < C_PEA)   f = S_ROJO1;
        else if (c < C_PARP)  f = S_PEATON;
        else if (c < C_FIN)   f = S_PARP;
        else if (c <= C_ULT)  f = S_ROJO2;
        else                  f = S_INICIO;
        return f;
    endfunction

    // Advance on the successor's first count, stay inside own window, otherwise resync
    function automatic fase_t avanza(input fase_t act, input fase_t sig,
                                     input logic [5:0] primero, input logic [5:0] c);
        fase_t f;
        if (c == primero)            f = sig;
        else if (ventana(c) == act)  f = act;
        else                         f = S_INICIO;
        return f;
    endfunction

    // Two-flop synchroniser and rising-edge detector, clocked every CLK
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= PEAT_REQ;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~prev_r;

    // Next-phase selection from the current phase and CUENTA
    always_comb begin
        state_nx_s = state_r;
        if (noche_s) begin
            state_nx_s = S_NOCHE;
        end else begin
            case (state_r)
                S_INICIO: state_nx_s = ventana(CUENTA);
                S_VERDE:  state_nx_s = avanza(S_VERDE,  S_AMBAR,  C_AMBAR, CUENTA);
                S_AMBAR:  state_nx_s = avanza(S_AMBAR,  S_ROJO1,  C_ROJO,  CUENTA);
                S_ROJO1:  state_nx_s = avanza(S_ROJO1,  S_PEATON, C_PEA,   CUENTA);
                S_PEATON: state_nx_s = avanza(S_PEATON, S_PARP,   C_PARP,  CUENTA);
                S_PARP:   state_nx_s = avanza(S_PARP,   S_ROJO2,  C_FIN,   CUENTA);
                S_ROJO2:  state_nx_s = avanza(S_ROJO2,  S_VERDE,  C_ZERO,  CUENTA);
                default:  state_nx_s = S_INICIO;
            endcase
        end
    end

    // Light decode of the phase being entered, registered alongside it
    always_comb begin
        luces_nx_s = L_TODO_ROJO;
        case (state_nx_s)
            S_INICIO: luces_nx_s = L_TODO_ROJO;
            S_VERDE:  luces_nx_s = L_VERDE;
            S_AMBAR:  luces_nx_s = L_AMBAR;
            S_ROJO1:  luces_nx_s = L_TODO_ROJO;
            S_PEATON: luces_nx_s = L_PEATON;
            S_PARP:   luces_nx_s = {4'b1000, CUENTA[0]};
            S_ROJO2:  luces_nx_s = L_TODO_ROJO;
            S_NOCHE:  luces_nx_s = {1'b0, CUENTA[1], 3'b000};
            default:  luces_nx_s = L_TODO_ROJO;
        endcase
    end

    // Phase and light registers move only on the counter enable
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= S_INICIO;
            luces_r <= L_TODO_ROJO;
        end else if (CLK_ENA) begin
            state_r <= state_nx_s;
            luces_r <= luces_nx_s;
        end
    end

    assign noche_act_s    = noche_s | (state_r == S_NOCHE);
    assign entra_peaton_s = CLK_ENA & (state_nx_s == S_PEATON) & (state_r != S_PEATON);
    assign fase_pide_s    = (state_r == S_VERDE) | (state_r == S_PARP) | (state_r == S_ROJO2);

    // Pending-request latch; clearing on PEATON entry beats a coincident edge
    always_comb begin
        espera_nx_s = espera_r;
        if (noche_act_s) begin
            espera_nx_s = 1'b0;
        end else if (entra_peaton_s) begin
            espera_nx_s = 1'b0;
        end else if (edge_s && fase_pide_s) begin
            espera_nx_s = 1'b1;
        end else begin
            espera_nx_s = espera_r;
        end
    end

    // Green-shortening load: held until the counter is seen at T_SALTO
    always_comb begin
        loadn_nx_s = loadn_r;
        p_nx_s     = p_r;
        if (noche_act_s) begin
            loadn_nx_s = 1'b1;
            p_nx_s     = C_ZERO;
        end else if (!loadn_r) begin
            if (CUENTA == C_SALTO) begin
                loadn_nx_s = 1'b1;
                p_nx_s     = C_ZERO;
            end else begin
                loadn_nx_s = 1'b0;
                p_nx_s     = C_SALTO;
            end
        end else if ((state_r == S_VERDE) && espera_r && (CUENTA < C_SALTO)) begin
            loadn_nx_s = 1'b0;
            p_nx_s     = C_SALTO;
        end else begin
            loadn_nx_s = 1'b1;
            p_nx_s     = C_ZERO;
        end
    end

    // Request and load registers run every CLK so no edge or handshake is lost
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            espera_r <= 1'b0;
            loadn_r  <= 1'b1;
            p_r      <= 6'd0;
        end else begin
            espera_r <= espera_nx_s;
            loadn_r  <= loadn_nx_s;
            p_r      <= p_nx_s;
        end
    end

    assign {CAR_R, CAR_A, CAR_V, PEA_R, PEA_V} = luces_r;
    assign PEAT_ESPERA = espera_r;
    assign SEM_LOADn   = loadn_r;
    assign SEM_P       = p_r;
    assign FASE        = state_r;

endmodule

// File: tb/tb_sem_fases.sv
// Self-checking bench for sem_fases: a counter model drives CUENTA and a phase-level
// reference predicts lights, pending request and load handshake every cycle.
module tb_sem_fases;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_ena = 1'b0;
    logic [5:0] cuenta = 6'd0;
    logic       tc;
    logic       peat_req = 1'b0;
    logic       sem_loadn;
    logic [5:0] sem_p;
    logic       car_r, car_a, car_v, pea_r, pea_v, peat_espera;
    logic [2:0] unused_fase;

    int vectors = 0;
    int miscompares = 0;

    localparam int P_INI = 0, P_V = 1, P_A = 2, P_R1 = 3, P_PEA = 4, P_PARP = 5, P_R2 = 6, P_NOCHE = 7;

    // reference model state
    int         m_phase;
    int         m_cnt;
    logic [4:0] m_lights;
    bit         m_esp, m_loadn, m_noche;
    bit         m_h0, m_h1, m_h2;

    assign tc = clk_ena && (cuenta == 6'd54);

    always #10 clk = ~clk;

`ifdef SEM_NOCHE_EN
    logic noche;
    assign noche = m_noche;
`endif

    sem_fases dut (
        .CLK(clk), .RSTn(rst_n),
`ifdef SEM_NOCHE_EN
        .NOCHE(noche),
`endif
        .CLK_ENA(clk_ena), .CUENTA(cuenta), .TC(tc), .PEAT_REQ(peat_req),
        .SEM_LOADn(sem_loadn), .SEM_P(sem_p),
        .CAR_R(car_r), .CAR_A(car_a), .CAR_V(car_v), .PEA_R(pea_r), .PEA_V(pea_v),
        .PEAT_ESPERA(peat_espera), .FASE(unused_fase)
    );

    function automatic int win(input int c);
        if (c < 20) return P_V;
        if (c < 24) return P_A;
        if (c < 26) return P_R1;
        if (c < 44) return P_PEA;
        if (c < 50) return P_PARP;
        if (c < 55) return P_R2;
        return P_INI;
    endfunction

    function automatic int first_of(input int ph);
        case (ph)
            P_V: return 0;   P_A: return 20;   P_R1: return 24;
            P_PEA: return 26; P_PARP: return 44; P_R2: return 50;
            default: return -1;
        endcase
    endfunction

    function automatic int succ(input int ph);
        return (ph == P_R2) ? P_V : ph + 1;
    endfunction

    // {CAR_R, CAR_A, CAR_V, PEA_R, PEA_V}
    function automatic logic [4:0] lights_of(input int ph, input logic [5:0] c);
        case (ph)
            P_V:     return 5'b00110;
            P_A:     return 5'b01010;
            P_PEA:   return 5'b10001;
            P_PARP:  return {4'b1000, c[0]};
            P_NOCHE: return {1'b0, c[1], 3'b000};
            default: return 5'b10010;
        endcase
    endfunction

    function automatic logic [12:0] obs_vec();
        return {car_r, car_a, car_v, pea_r, pea_v, peat_espera, sem_loadn, sem_p};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_lights, m_esp, m_loadn, (m_loadn ? 6'd0 : 6'd12)};
    endfunction

    task automatic reset_model();
        m_phase = P_INI; m_cnt = 0; m_lights = 5'b10010;
        m_esp = 1'b0; m_loadn = 1'b1; m_noche = 1'b0;
        m_h0 = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
    endtask

    // Drive one cycle of inputs at the negedge, predict the next edge, land on the next negedge
    task automatic step(input bit ena, input bit req, input logic [5:0] cue);
        int old_ph, new_ph, w;
        bit edge_m, old_esp, old_loadn;
        clk_ena = ena; peat_req = req; cuenta = cue;
        old_ph = m_phase; old_esp = m_esp; old_loadn = m_loadn;
        edge_m = m_h1 && !m_h2;
        w = win(int'(cue));
        new_ph = old_ph;
        if (ena) begin
            if (m_noche) new_ph = P_NOCHE;
            else if (old_ph == P_NOCHE) new_ph = P_INI;
            else if (old_ph == P_INI) new_ph = w;
            else if (w == old_ph) new_ph = old_ph;
            else if (w == succ(old_ph) && int'(cue) == first_of(w)) new_ph = w;
            else new_ph = P_INI;
            m_lights = lights_of(new_ph, cue);
        end
        if (m_noche || old_ph == P_NOCHE) m_esp = 1'b0;
        else if (ena && new_ph == P_PEA && old_ph != P_PEA) m_esp = 1'b0;
        else if (edge_m && (old_ph == P_V || old_ph == P_PARP || old_ph == P_R2)) m_esp = 1'b1;
        if (m_noche || old_ph == P_NOCHE) m_loadn = 1'b1;
        else if (!old_loadn) m_loadn = (cue == 6'd12);
        else if (old_ph == P_V && old_esp && cue < 6'd12) m_loadn = 1'b0;
        m_phase = new_ph;
        m_h2 = m_h1; m_h1 = m_h0; m_h0 = req;
        if (ena) m_cnt = !old_loadn ? 12 : ((cue == 6'd54) ? 0 : int'(cue) + 1);
        else m_cnt = int'(cue);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_ena = 1'b0; peat_req = 1'b0; cuenta = 6'd0;
        reset_model();
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_vec() !== {5'b10010, 1'b0, 1'b1, 6'd0}) begin
            miscompares++; $display("FAIL reset_state: got %b expected %b", obs_vec(), {5'b10010, 1'b0, 1'b1, 6'd0});
        end
        rst_n = 1'b1;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL inicio_all_red: got %b expected %b", obs_vec(), exp_vec());
        end
        step(1'b1, 1'b0, 6'd0);
        vectors++;
        if ({car_r, car_a, car_v, pea_r, pea_v} !== 5'b00110) begin
            miscompares++; $display("FAIL first_verde: got %b expected %b", {car_r, car_a, car_v, pea_r, pea_v}, 5'b00110);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 62; i++) begin
            step(1'b1, 1'b0, 6'(m_cnt));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL sweep cnt=%0d: got %b expected %b", cuenta, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_short_req();
        int guard = 0;
        bit saw_load = 1'b0;
        while (m_cnt != 5 && guard < 200) begin
            step(1'b1, 1'b0, 6'(m_cnt)); guard++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL short_pre: got %b expected %b", obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (guard >= 200) begin
            miscompares++; $display("FAIL short_reach5: got cnt %0d expected 5", m_cnt);
        end
        for (int i = 0; i < 45; i++) begin
            step(1'b1, (i < 2), 6'(m_cnt));
            if (!sem_loadn && sem_p == 6'd12) saw_load = 1'b1;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL short_req cnt=%0d: got %b expected %b", cuenta, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (!saw_load) begin
            miscompares++; $display("FAIL short_load_seen: got no load expected SEM_LOADn=0 SEM_P=12");
        end
    endtask

    task automatic test_late_req();
        int guard = 0;
        while (m_cnt != 15 && guard < 200) begin
            step(1'b1, 1'b0, 6'(m_cnt)); guard++;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i < 2), 6'(m_cnt));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL late15 cnt=%0d: got %b expected %b", cuenta, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (sem_loadn !== 1'b1 || peat_espera !== 1'b1) begin
            miscompares++; $display("FAIL late15_no_load: got loadn=%b esp=%b expected loadn=1 esp=1", sem_loadn, peat_espera);
        end
        guard = 0;
        while (m_cnt != 30 && guard < 200) begin
            step(1'b1, 1'b0, 6'(m_cnt)); guard++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL late_mid cnt=%0d: got %b expected %b", cuenta, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i < 2), 6'(m_cnt));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL late30 cnt=%0d: got %b expected %b", cuenta, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (peat_espera !== 1'b0) begin
            miscompares++; $display("FAIL peaton_ignore: got esp=%b expected 0", peat_espera);
        end
    endtask

    task automatic test_resync();
        int guard = 0;
        while (m_cnt != 30 && guard < 200) begin
            step(1'b1, 1'b0, 6'(m_cnt)); guard++;
        end
        step(1'b1, 1'b0, 6'd5);
        vectors++;
        if ({car_r, car_a, car_v, pea_r, pea_v} !== 5'b10010 || obs_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL resync_inicio: got %b expected %b", obs_vec(), exp_vec());
        end
        step(1'b1, 1'b0, 6'(m_cnt));
        vectors++;
        if ({car_r, car_a, car_v, pea_r, pea_v} !== 5'b00110 || obs_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL resync_verde: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit req = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 11) == 0) req = ~req;
            step(($urandom_range(0, 3) != 0), req, 6'(m_cnt));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL random i=%0d cnt=%0d: got %b expected %b", i, cuenta, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'(m_cnt));
    endtask

    task automatic test_reset_mid_load();
        int guard = 0;
        while (m_cnt != 2 && guard < 300) begin
            step(1'b1, 1'b0, 6'(m_cnt)); guard++;
        end
        guard = 0;
        while (m_loadn && guard < 30) begin
            step(1'b1, (guard < 2), 6'(m_cnt)); guard++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL midload_pre: got %b expected %b", obs_vec(), exp_vec());
            end
        end
        peat_req = 1'b0;
        vectors++;
        if (sem_loadn !== 1'b0) begin
            miscompares++; $display("FAIL midload_active: got loadn=%b expected 0", sem_loadn);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sem_loadn, car_r, car_v, sem_p} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
            miscompares++; $display("FAIL midload_async: got %b expected %b", {sem_loadn, car_r, car_v, sem_p}, {1'b1, 1'b1, 1'b0, 6'd0});
        end
        @(negedge clk);
        reset_model();
        rst_n = 1'b1;
    endtask

`ifdef SEM_NOCHE_EN
    task automatic test_noche();
        int guard = 0;
        while (m_cnt != 30 && guard < 200) begin
            step(1'b1, 1'b0, 6'(m_cnt)); guard++;
        end
        m_noche = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 6'(m_cnt));
            vectors++;
            if (obs_vec() !== exp_vec() || pea_v !== 1'b0) begin
                miscompares++; $display("FAIL noche cnt=%0d: got %b expected %b", cuenta, obs_vec(), exp_vec());
            end
        end
        m_noche = 1'b0;
        step(1'b1, 1'b0, 6'(m_cnt));
        vectors++;
        if ({car_r, car_a, car_v, pea_r, pea_v} !== 5'b10010) begin
            miscompares++; $display("FAIL noche_inicio: got %b expected %b", {car_r, car_a, car_v, pea_r, pea_v}, 5'b10010);
        end
        step(1'b1, 1'b0, 6'(m_cnt));
        vectors++;
        if ({car_r, car_a, car_v, pea_r, pea_v} !== 5'b10001) begin
            miscompares++; $display("FAIL noche_peaton: got %b expected %b", {car_r, car_a, car_v, pea_r, pea_v}, 5'b10001);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_model();
        @(negedge clk);
        test_reset();
        test_sweep();
        test_short_req();
        test_late_req();
        test_resync();
        test_random();
        test_reset_mid_load();
        test_sweep();
`ifdef SEM_NOCHE_EN
        test_noche();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
